// File: rtl/nibble_acc_pkg.sv
// Shared definitions for the nibble accumulator.
//
// Contents:
//   IN_W / OUT_W  - sample and sum widths (4-bit samples, 8-bit sums)
//   CNT_W         - width of the per-frame sample counter
//   state_t       - frame state: ACCUM (taking samples) / HOLD (sum presented)
//   SAT_MAX/MIN   - clamp limits used when SATURATE_EN is defined
package nibble_acc_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 8;
  localparam int CNT_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic signed [OUT_W-1:0] SAT_MAX = 8'sh7F;
  localparam logic signed [OUT_W-1:0] SAT_MIN = 8'sh80;

endpackage

// File: rtl/sign_extend_4to8.sv
// Combinational sign extension of a 4-bit two's-complement sample to 8 bits.
//
// Ports:
//   din  - 4-bit signed sample
//   dout - 8-bit signed value, bit 3 of din replicated into the upper bits
module sign_extend_4to8
  import nibble_acc_pkg::*;
(
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/nibble_accumulator.sv
// Frame accumulator: sums COUNT signed 4-bit samples into an 8-bit signed
// frame sum, then holds the sum on a valid/ready output until it is taken.
//
// Parameters:
//   COUNT     - samples per frame, 1..255
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - upstream sample present
//   in_ready  - high while accumulating (sample accepted on valid & ready)
//   in_value  - 4-bit two's-complement sample
//   out_valid - frame sum available (HOLD state)
//   out_ready - downstream takes the sum
//   out_sum   - current accumulator value (the frame sum while out_valid)
//   out_ovf   - an addition in this frame clamped
//
// Build option:
//   SATURATE_EN - when defined, each addition clamps to +127/-128 on signed
//                 overflow and sets out_ovf until the frame is taken or reset.
//                 When undefined, additions wrap modulo 256 and out_ovf is 0.
module nibble_accumulator
  import nibble_acc_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

`ifdef SATURATE_EN
  // Returns {clamped, sum}. Overflow is detected by the two top bits of the
  // 9-bit sum disagreeing; the top bit then gives the true sign.
  function automatic logic [OUT_W:0] add_sat(input logic signed [OUT_W-1:0] a,
                                             input logic signed [OUT_W-1:0] b);
    logic signed [OUT_W:0] wide;
    wide = $signed({a[OUT_W-1], a}) + $signed({b[OUT_W-1], b});
    if (wide[OUT_W] != wide[OUT_W-1]) begin
      return {1'b1, (wide[OUT_W] ? SAT_MIN : SAT_MAX)};
    end
    return {1'b0, wide[OUT_W-1:0]};
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] add_wrap(input logic signed [OUT_W-1:0] a,
                                                       input logic signed [OUT_W-1:0] b);
    return a + b;
  endfunction
`endif

  state_t                   state_q;
  state_t                   state_d;
  logic signed [OUT_W-1:0]  ext_p0;
  logic signed [OUT_W-1:0]  sum_p0;
  logic signed [OUT_W-1:0]  acc_p1;
  logic        [CNT_W-1:0]  cnt_p1;
  logic                     vld_p0;
  logic                     take;

  // ---- stage p0: sign extension and adder (combinational) ----
  sign_extend_4to8 u_ext (
    .din  (in_value),
    .dout (ext_p0)
  );

`ifdef SATURATE_EN
  logic [OUT_W:0] sat_res_p0;
  logic           clip_p0;
  logic           ovf_p1;
  assign sat_res_p0 = add_sat(acc_p1, ext_p0);
  assign sum_p0     = sat_res_p0[OUT_W-1:0];
  assign clip_p0    = sat_res_p0[OUT_W];
  assign out_ovf    = ovf_p1;
`else
  assign sum_p0  = add_wrap(acc_p1, ext_p0);
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    vld_p0    = 1'b0;
    take      = 1'b0;
    case (state_q)
      ACCUM: begin
        vld_p0 = in_valid;
        if (in_valid && (cnt_p1 == LAST)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        take = out_ready;
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // ---- stage p1: accumulator, counter, overflow flag ----
  // acc_p1 only moves on an accept or a take, so it is frozen in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_p1  <= '0;
      cnt_p1  <= '0;
`ifdef SATURATE_EN
      ovf_p1  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (vld_p0) begin
        acc_p1 <= sum_p0;
        cnt_p1 <= cnt_p1 + 8'd1;
`ifdef SATURATE_EN
        ovf_p1 <= ovf_p1 | clip_p0;
`endif
      end else if (take) begin
        acc_p1 <= '0;
        cnt_p1 <= '0;
`ifdef SATURATE_EN
        ovf_p1 <= 1'b0;
`endif
      end
    end
  end

  assign out_sum = acc_p1;

endmodule

// File: tb/tb_nibble_accumulator.sv
// Testbench for nibble_accumulator: three instances (COUNT = 4, 20, 1) share
// one clock and reset. A frame-level model predicts in_ready/out_valid/
// out_sum/out_ovf for each instance and is compared every cycle; directed
// frames additionally pin hand-computed sums.
module tb_nibble_accumulator;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [ND];
  logic       in_ready  [ND];
  logic [3:0] in_value  [ND];
  logic       out_valid [ND];
  logic       out_ready [ND];
  logic [7:0] out_sum   [ND];
  logic       out_ovf   [ND];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_accumulator #(.COUNT(4)) u_c4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_value(in_value[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_ovf(out_ovf[0])
  );

  nibble_accumulator #(.COUNT(20)) u_c20 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_value(in_value[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]), .out_ovf(out_ovf[1])
  );

  nibble_accumulator #(.COUNT(1)) u_c1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_value(in_value[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(out_sum[2]), .out_ovf(out_ovf[2])
  );

  // ---------------- frame-level model ----------------
  int m_sum  [ND];
  int m_n    [ND];
  bit m_hold [ND];
  bit m_ovf  [ND];

  function automatic int count_of(input int d);
    case (d)
      0:       return 4;
      1:       return 20;
      default: return 1;
    endcase
  endfunction

  function automatic int ext4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Bring an exact integer sum back into the 8-bit signed result range.
  function automatic int fold(input int s);
    int w;
`ifdef SATURATE_EN
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
`else
    w = s & 32'hFF;
    return (w > 127) ? w - 256 : w;
`endif
  endfunction

  function automatic bit clipped(input int s);
`ifdef SATURATE_EN
    return (s > 127) || (s < -128);
`else
    return (s != s);
`endif
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_sum[d]  <= 0;
        m_n[d]    <= 0;
        m_hold[d] <= 1'b0;
        m_ovf[d]  <= 1'b0;
      end else if (!m_hold[d]) begin
        if (in_valid[d]) begin
          m_sum[d] <= fold(m_sum[d] + ext4(in_value[d]));
          m_ovf[d] <= m_ovf[d] | clipped(m_sum[d] + ext4(in_value[d]));
          m_n[d]   <= m_n[d] + 1;
          if (m_n[d] + 1 == count_of(d)) m_hold[d] <= 1'b1;
        end
      end else if (out_ready[d]) begin
        m_sum[d]  <= 0;
        m_n[d]    <= 0;
        m_hold[d] <= 1'b0;
        m_ovf[d]  <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      logic [10:0] act;
      logic [10:0] exp;
      act = {in_ready[d], out_valid[d], out_sum[d], out_ovf[d]};
      exp = {!m_hold[d], m_hold[d], 8'(m_sum[d]), m_ovf[d]};
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL model[%0d] t=%0t: rdy/vld/sum/ovf got %b/%b/%h/%b expected %b/%b/%h/%b",
                 d, $time, act[10], act[9], act[8:1], act[0],
                 exp[10], exp[9], exp[8:1], exp[0]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [3:0] v);
    in_valid[d] = 1'b1;
    in_value[d] = v;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic idle(input int d, input logic [3:0] junk);
    in_value[d] = junk;
    @(posedge clk); #1;
  endtask

  task automatic take(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  initial begin
    logic [3:0] frame_a [4];
    logic [3:0] frame_g [4];
    frame_a = '{4'b1010, 4'b1101, 4'b0011, 4'b0111};
    frame_g = '{4'h2, 4'hF, 4'h4, 4'h9};
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      in_value[d]  = 4'h0;
      out_ready[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sum", {24'd0, out_sum[0]}, 32'h00);
    chk("reset_ctl", {29'd0, in_ready[0], out_valid[0], out_ovf[0]}, 32'b100);
    rst = 1'b0;

    // Basic frame: -6 -3 +3 +7 = 1, valid one cycle after the 4th accept.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("basic_not_early", {31'd0, out_valid[0]}, 32'd0);
      send(0, frame_a[i]);
    end
    chk("basic_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("basic_sum", {24'd0, out_sum[0]}, 32'h01);
    chk("basic_ovf", {31'd0, out_ovf[0]}, 32'd0);

    // Backpressure: five cycles held, then take with a sample offered.
    for (int i = 0; i < 5; i++) begin
      idle(0, 4'h0);
      chk("bp_hold", {22'd0, in_ready[0], out_valid[0], out_sum[0]}, {22'd0, 2'b01, 8'h01});
    end
    in_valid[0] = 1'b1;
    in_value[0] = 4'h5;
    take(0);
    in_valid[0] = 1'b0;
    chk("take_clear", {22'd0, in_ready[0], out_valid[0], out_sum[0]}, {22'd0, 2'b10, 8'h00});

    // Reset mid-frame discards the partial sum.
    send(0, 4'h3);
    send(0, 4'h6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_sum", {23'd0, out_valid[0], out_sum[0]}, 32'h000);
    for (int i = 0; i < 4; i++) send(0, 4'b0001);
    chk("after_rst_sum", {23'd0, out_valid[0], out_sum[0]}, 32'h104);
    take(0);

    // Gapped input: 2 -1 +4 -7 = -2, junk on idle cycles must be ignored.
    for (int i = 0; i < 4; i++) begin
      send(0, frame_g[i]);
      if (i < 3) begin
        chk("gap_not_valid", {31'd0, out_valid[0]}, 32'd0);
        idle(0, 4'h7);
      end
    end
    chk("gap_sum", {23'd0, out_valid[0], out_sum[0]}, 32'h1FE);
    take(0);

    // Positive overflow: twenty samples of +7 (exact sum 140).
    for (int i = 0; i < 20; i++) send(1, 4'b0111);
`ifdef SATURATE_EN
    chk("pos_ovf", {22'd0, out_valid[1], out_ovf[1], out_sum[1]}, {22'd0, 2'b11, 8'h7F});
`else
    chk("pos_ovf", {22'd0, out_valid[1], out_ovf[1], out_sum[1]}, {22'd0, 2'b10, 8'h8C});
`endif
    take(1);
    chk("pos_cleared", {23'd0, out_ovf[1], out_sum[1]}, 32'h000);

    // Negative overflow: twenty samples of -8 (exact sum -160).
    for (int i = 0; i < 20; i++) send(1, 4'b1000);
`ifdef SATURATE_EN
    chk("neg_ovf", {22'd0, out_valid[1], out_ovf[1], out_sum[1]}, {22'd0, 2'b11, 8'h80});
`else
    chk("neg_ovf", {22'd0, out_valid[1], out_ovf[1], out_sum[1]}, {22'd0, 2'b10, 8'h60});
`endif
    take(1);

    // COUNT=1: every accept goes straight to HOLD.
    send(2, 4'b1000);
    chk("c1_neg", {23'd0, out_valid[2], out_sum[2]}, 32'h1F8);
    take(2);
    send(2, 4'b0011);
    chk("c1_pos", {23'd0, out_valid[2], out_sum[2]}, 32'h103);

    // Reset while holding drops the held sum.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("hold_rst", {22'd0, in_ready[2], out_valid[2], out_sum[2]}, {22'd0, 2'b10, 8'h00});

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
